// File: rtl/hpdmc_fmlarb.sv
// -----------------------------------------------------------------------------
// hpdmc_fmlarb
//   Shares the single FML port of the hpdmc SDRAM controller among N bus
//   masters. Round-robin arbitration, one transaction in flight at a time.
//   The write enable is latched at grant and held through the data phase,
//   because hpdmc derives its ack latency from fml_we. A watchdog aborts a
//   data phase whose ack never arrives.
//
//   Build option: FMLARB_PRIO_EN
//     defined   - master 0 is fixed highest priority; masters 1..N-1 share
//                 the remaining slots round-robin.
//     undefined - pure round-robin over all N masters.
//
// Parameters
//   N            number of masters (2..8)
//   sdram_depth  FML byte-address width
//   TIMEOUT      maximum data-phase cycles before abort (1..63)
//
// Ports
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   m_adr/m_stb/m_we/m_sel/m_di master request buses, master i in slice i
//   m_eack, m_ack               address / data acks, one-hot to the owner
//   m_do                        read data broadcast to all masters
//   fml_adr/stb/we/sel/di       request towards hpdmc
//   fml_eack, fml_ack, fml_do   responses from hpdmc
//   timeout_err                 one-cycle pulse when the watchdog aborts
// -----------------------------------------------------------------------------
module hpdmc_fmlarb #(
    parameter int N           = 4,
    parameter int sdram_depth = 25,
    parameter int TIMEOUT     = 63
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [N*sdram_depth-1:0]  m_adr,
    input  logic [N-1:0]              m_stb,
    input  logic [N-1:0]              m_we,
    input  logic [N*4-1:0]            m_sel,
    input  logic [N*32-1:0]           m_di,
    output logic [N-1:0]              m_eack,
    output logic [N-1:0]              m_ack,
    output logic [31:0]               m_do,
    output logic [sdram_depth-1:0]    fml_adr,
    output logic                      fml_stb,
    output logic                      fml_we,
    output logic [3:0]                fml_sel,
    output logic [31:0]               fml_di,
    input  logic                      fml_eack,
    input  logic                      fml_ack,
    input  logic [31:0]               fml_do,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Lowest master index taking part in the round-robin scan.
`ifdef FMLARB_PRIO_EN
    localparam int RR_BASE = 1;
`else
    localparam int RR_BASE = 0;
`endif

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2:0]             r_owner;
    logic [2:0]             r_last;
    logic                   r_we;
    logic [5:0]             r_cnt;

    logic                   w_req_valid;
    logic [2:0]             w_next_owner;
    logic                   w_next_we;
    logic [N-1:0]           w_owner_oh;
    logic [sdram_depth-1:0] w_adr;
    logic [3:0]             w_sel;
    logic [31:0]            w_di;
    logic                   w_timeout;

    // Arbitration: the first requester found at distance 1, 2, .. N after
    // the last owner wins. Distance is resolved by comparing against both
    // j and j+N, which avoids a variable modulo.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_req_valid  = 1'b0;
        w_next_owner = '0;
        w_next_we    = 1'b0;
`ifdef FMLARB_PRIO_EN
        if (m_stb[0]) begin
            w_req_valid  = 1'b1;
            w_next_owner = '0;
            w_next_we    = m_we[0];
        end
`endif
        for (int k = 1; k <= N; k++) begin
            for (int j = RR_BASE; j < N; j++) begin
                if (!w_req_valid && m_stb[j] &&
                    ((int'(r_last) + k == j) || (int'(r_last) + k == j + N))) begin
                    w_req_valid  = 1'b1;
                    w_next_owner = 3'(j);
                    w_next_we    = m_we[j];
                end
            end
        end
    end

    // Owner decode and request-bus muxes.
    always_comb begin
        w_owner_oh = '0;
        w_adr      = '0;
        w_sel      = '0;
        w_di       = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == 3'(i)) begin
                w_owner_oh[i] = 1'b1;
                w_adr         = m_adr[i*sdram_depth +: sdram_depth];
                w_sel         = m_sel[i*4 +: 4];
                w_di          = m_di[i*32 +: 32];
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_LAST);

    // Next state and control outputs. Acks from hpdmc are forwarded only in
    // the phase they belong to; an ack arriving with the timeout wins.
    always_comb begin
        w_state_next = r_state;
        fml_stb      = 1'b0;
        fml_we       = 1'b0;
        m_eack       = '0;
        m_ack        = '0;
        timeout_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_valid) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                // No watchdog here: refresh/precharge may stall the address phase.
                fml_stb = 1'b1;
                fml_we  = r_we;
                m_eack  = w_owner_oh & {N{fml_eack}};
                if (fml_eack) w_state_next = S_DATA;
            end
            S_DATA: begin
                fml_we = r_we;
                m_ack  = w_owner_oh & {N{fml_ack}};
                if (fml_ack) begin
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    timeout_err  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= 3'(N - 1);
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req_valid) begin
                        r_owner <= w_next_owner;
                        r_we    <= w_next_we;
                    end
                end
                S_ADDR: begin
                    if (fml_eack) r_cnt <= '0;
                end
                S_DATA: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_state_next == S_IDLE) r_last <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign fml_adr = w_adr;
    assign fml_sel = w_sel;
    assign fml_di  = w_di;
    assign m_do    = fml_do;

endmodule
